// File: rtl/turbo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// turbo_ctrl_pkg
// Shared definitions for the SISO recursion controllers (alpha and beta side).
//   beta_ctrl_state_t   : backward-recursion controller FSM states
//   state/branch vector : packed metric-vector typedefs for the default widths
//   neg_init()          : "minus infinity" seed used for non-zero start states
// Metric vectors pack state s (or symbol s) in bits [s*BITS +: BITS].
// -----------------------------------------------------------------------------
package turbo_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } beta_ctrl_state_t;

    localparam int unsigned DEF_BITS           = 16;
    localparam int unsigned DEF_STATES         = 4;
    localparam int unsigned DEF_OUTPUT_SYMBOLS = 4;

    typedef logic [DEF_BITS*DEF_STATES-1:0]         state_metric_vec_t;
    typedef logic [DEF_BITS*DEF_OUTPUT_SYMBOLS-1:0] branch_metric_vec_t;

    // -2^(bits-2): far enough below zero to lose every max() against the
    // real start state, yet leaves headroom so a few additions cannot wrap.
    function automatic logic [63:0] neg_init(input int unsigned bits);
        return 64'd0 - (64'd1 << (bits - 2));
    endfunction

endpackage

// File: rtl/beta_norm.sv
// -----------------------------------------------------------------------------
// beta_norm
// Combinational normalisation of a beta vector: subtracts the state-0 metric
// from every state so state 0 always reads zero. Arithmetic wraps mod 2^BITS.
// Ports:
//   in_beta  in  BITS*STATES  raw beta vector (state s at [s*BITS +: BITS])
//   out_beta out BITS*STATES  normalised beta vector
// -----------------------------------------------------------------------------
module beta_norm
    import turbo_ctrl_pkg::*;
#(
    parameter int BITS   = 16,
    parameter int STATES = 4
) (
    input  logic [BITS*STATES-1:0] in_beta,
    output logic [BITS*STATES-1:0] out_beta
);

    always_comb begin
        for (int s = 0; s < STATES; s++) begin
            out_beta[s*BITS +: BITS] = in_beta[s*BITS +: BITS] - in_beta[BITS-1:0];
        end
    end

endmodule

// File: rtl/beta_recursion_ctrl.sv
// -----------------------------------------------------------------------------
// beta_recursion_ctrl
// Sequences the backward (beta) recursion of a max-product SISO decoder over
// one code block. Branch metrics are read in descending trellis index, each
// step is handed to a single beta_element, whose result is fed back as the
// next step's nextBeta and written to the beta RAM for the LLR stage.
//
// Optional build macro: BETA_RECURSION_CTRL_NORM_EN
//   defined   -> each latched beta vector is normalised to state 0 (beta_norm)
//   undefined -> beta vectors are latched unmodified
//
// Vector packing: state s / symbol s occupies bits [s*BITS +: BITS].
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 one-cycle start pulse (only honoured in IDLE)
//   abort                 synchronous cancel of the running block
//   block_len             number of trellis steps N (0 .. 2^ADDR_BITS)
//   terminated            trellis terminated in state 0
//   busy, done            status; done is a one-cycle end-of-block pulse
//   bm_rd_en/addr/data    branch-metric RAM read port (data one cycle later)
//   elem_*                handshake with the beta_element datapath
//   beta_wr_en/addr/data  beta RAM write port
// -----------------------------------------------------------------------------
module beta_recursion_ctrl
    import turbo_ctrl_pkg::*;
#(
    parameter int BITS           = 16,
    parameter int STATES         = 4,
    parameter int OUTPUT_SYMBOLS = 4,
    parameter int ADDR_BITS      = 10,
    parameter int ELEM_LATENCY   = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [ADDR_BITS:0]               block_len,
    input  logic                             terminated,
    output logic                             busy,
    output logic                             done,
    output logic                             bm_rd_en,
    output logic [ADDR_BITS-1:0]             bm_rd_addr,
    input  logic [BITS*OUTPUT_SYMBOLS-1:0]   bm_rd_data,
    output logic                             elem_in_valid,
    output logic [BITS*OUTPUT_SYMBOLS-1:0]   elem_branch_metric,
    output logic [BITS*STATES-1:0]           elem_next_beta,
    input  logic                             elem_out_valid,
    input  logic [BITS*STATES-1:0]           elem_beta,
    output logic                             beta_wr_en,
    output logic [ADDR_BITS-1:0]             beta_wr_addr,
    output logic [BITS*STATES-1:0]           beta_wr_data
);

    // The WAIT state simply follows elem_out_valid, so the latency only has
    // to be legal; the step period falls out as ELEM_LATENCY+3.
    generate
        if (ELEM_LATENCY < 1) begin : g_bad_latency
            $error("beta_recursion_ctrl: ELEM_LATENCY must be at least 1");
        end
    endgenerate

    localparam logic [BITS-1:0] NEG_INIT = BITS'(neg_init(BITS));

    beta_ctrl_state_t              state;
    beta_ctrl_state_t              state_nxt;
    logic [ADDR_BITS-1:0]          k;
    logic                          term_reg;
    logic [BITS*STATES-1:0]        beta_reg;
    logic [BITS*STATES-1:0]        init_beta;
    logic [BITS*STATES-1:0]        latch_value;

    // Value captured from the element on out_valid.
`ifdef BETA_RECURSION_CTRL_NORM_EN
    beta_norm #(
        .BITS   (BITS),
        .STATES (STATES)
    ) u_beta_norm (
        .in_beta  (elem_beta),
        .out_beta (latch_value)
    );
`else
    assign latch_value = elem_beta;
`endif

    // Seed vector: a terminated trellis ends in state 0, so every other state
    // starts at "minus infinity"; otherwise all end states are equally likely.
    always_comb begin
        for (int s = 0; s < STATES; s++) begin
            init_beta[s*BITS +: BITS] = (term_reg && s != 0) ? NEG_INIT : '0;
        end
    end

    // Next-state logic. abort outranks everything, including an element
    // result arriving in the same cycle.
    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and
        // no latch is inferred.
        state_nxt = state;
        if (abort && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (start) state_nxt = (block_len == '0) ? ST_DONE : ST_INIT;
                ST_INIT:  state_nxt = ST_READ;
                ST_READ:  state_nxt = ST_ISSUE;
                ST_ISSUE: state_nxt = ST_WAIT;
                ST_WAIT:  if (elem_out_valid) state_nxt = ST_WRITE;
                ST_WRITE: state_nxt = (k == '0) ? ST_DONE : ST_READ;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            k        <= '0;
            term_reg <= 1'b0;
            beta_reg <= '0;
        end else begin
            state <= state_nxt;
            // An abort freezes the datapath registers; beta_reg keeps the last
            // completed step.
            if (!abort || state == ST_IDLE) begin
                unique case (state)
                    ST_IDLE: begin
                        if (start && block_len != '0) begin
                            // N = 2^ADDR_BITS has zero low bits; the wrap
                            // yields the all-ones top index.
                            k        <= block_len[ADDR_BITS-1:0] - 1'b1;
                            term_reg <= terminated;
                        end
                    end
                    ST_INIT:  beta_reg <= init_beta;
                    ST_WAIT:  if (elem_out_valid) beta_reg <= latch_value;
                    ST_WRITE: if (k != '0) k <= k - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Outputs decode from the state register only; idle values are zero.
    always_comb begin
        busy               = (state != ST_IDLE);
        done               = (state == ST_DONE);
        bm_rd_en           = (state == ST_READ);
        bm_rd_addr         = (state == ST_READ) ? k : '0;
        elem_in_valid      = (state == ST_ISSUE);
        // Read data lands exactly in the ISSUE cycle, so it passes straight
        // through without a holding register.
        elem_branch_metric = (state == ST_ISSUE) ? bm_rd_data : '0;
        elem_next_beta     = (state == ST_ISSUE || state == ST_WAIT) ? beta_reg : '0;
        beta_wr_en         = (state == ST_WRITE);
        beta_wr_addr       = (state == ST_WRITE) ? k : '0;
        beta_wr_data       = (state == ST_WRITE) ? beta_reg : '0;
    end

endmodule

// File: tb/tb_beta_recursion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_beta_recursion_ctrl
// Self-checking bench: a branch-metric RAM model, a stand-in beta_element with
// ELEM_LATENCY pipeline, a negedge monitor, and a reference model that walks
// the recursion directly from the trellis definition.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_beta_recursion_ctrl;

    localparam int BITS           = 16;
    localparam int STATES         = 4;
    localparam int OUTPUT_SYMBOLS = 4;
    localparam int ADDR_BITS      = 10;
    localparam int ELEM_LATENCY   = 2;
    localparam int VW     = BITS * STATES;
    localparam int BW     = BITS * OUTPUT_SYMBOLS;
    localparam int PERIOD = ELEM_LATENCY + 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [ADDR_BITS:0]   block_len = '0;
    logic                 terminated = 1'b0;
    logic                 busy, done, bm_rd_en, elem_in_valid, beta_wr_en;
    logic [ADDR_BITS-1:0] bm_rd_addr, beta_wr_addr;
    logic [BW-1:0]        bm_rd_data = '0;
    logic [BW-1:0]        elem_branch_metric;
    logic [VW-1:0]        elem_next_beta, beta_wr_data, elem_beta;
    logic                 elem_out_valid;

    always #5 clk = ~clk;

    beta_recursion_ctrl #(
        .BITS(BITS), .STATES(STATES), .OUTPUT_SYMBOLS(OUTPUT_SYMBOLS),
        .ADDR_BITS(ADDR_BITS), .ELEM_LATENCY(ELEM_LATENCY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .block_len(block_len), .terminated(terminated),
        .busy(busy), .done(done),
        .bm_rd_en(bm_rd_en), .bm_rd_addr(bm_rd_addr), .bm_rd_data(bm_rd_data),
        .elem_in_valid(elem_in_valid), .elem_branch_metric(elem_branch_metric),
        .elem_next_beta(elem_next_beta), .elem_out_valid(elem_out_valid),
        .elem_beta(elem_beta),
        .beta_wr_en(beta_wr_en), .beta_wr_addr(beta_wr_addr), .beta_wr_data(beta_wr_data)
    );

    int   check_count = 0;
    int   err_count   = 0;
    int   cyc  = 0;
    int   base = 0;
    int   elem_mode = 0;
    logic spur = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- environment models ----------------
    logic [BW-1:0] bm_mem [0:(1<<ADDR_BITS)-1];

    always @(posedge clk) if (bm_rd_en) bm_rd_data <= bm_mem[bm_rd_addr];

    // Element behaviour: mode 0 -> nextBeta+1, mode 1 -> constant
    // {100,90,80,70} (state 0..3), mode 2 -> nextBeta[s] + bm[s].
    function automatic logic [VW-1:0] elem_fn(input int mode, input logic [VW-1:0] nb,
                                              input logic [BW-1:0] bm);
        logic [VW-1:0] r;
        r = '0;
        for (int s = 0; s < STATES; s++) begin
            case (mode)
                0:       r[s*BITS +: BITS] = nb[s*BITS +: BITS] + BITS'(1);
                1:       r[s*BITS +: BITS] = BITS'(100 - 10 * s);
                default: r[s*BITS +: BITS] = nb[s*BITS +: BITS] + bm[(s % OUTPUT_SYMBOLS)*BITS +: BITS];
            endcase
        end
        return r;
    endfunction

    logic          pv [ELEM_LATENCY];
    logic [VW-1:0] pd [ELEM_LATENCY];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ELEM_LATENCY; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= elem_in_valid;
            pd[0] <= elem_fn(elem_mode, elem_next_beta, elem_branch_metric);
            for (int i = 1; i < ELEM_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign elem_out_valid = pv[ELEM_LATENCY-1] | spur;
    assign elem_beta      = pd[ELEM_LATENCY-1];

    // ---------------- monitor ----------------
    int            rd_addr_q[$], rd_cyc_q[$], is_cyc_q[$], wr_addr_q[$], wr_cyc_q[$];
    int            done_cyc_q[$], ov_cyc_q[$];
    logic [VW-1:0] is_nb_q[$], wr_data_q[$];
    logic [BW-1:0] is_bm_q[$];
    int            busy_cycles;

    always @(negedge clk) begin
        if (!reset) begin
            if (bm_rd_en) begin rd_addr_q.push_back(int'(bm_rd_addr)); rd_cyc_q.push_back(cyc - base); end
            if (elem_in_valid) begin
                is_nb_q.push_back(elem_next_beta);
                is_bm_q.push_back(elem_branch_metric);
                is_cyc_q.push_back(cyc - base);
            end
            if (beta_wr_en) begin
                wr_addr_q.push_back(int'(beta_wr_addr));
                wr_data_q.push_back(beta_wr_data);
                wr_cyc_q.push_back(cyc - base);
            end
            if (done) done_cyc_q.push_back(cyc - base);
            if (pv[ELEM_LATENCY-1]) ov_cyc_q.push_back(cyc - base);
            if (busy) busy_cycles++;
        end
    end

    task automatic clear_mon();
        rd_addr_q.delete(); rd_cyc_q.delete(); is_cyc_q.delete(); is_nb_q.delete();
        is_bm_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        done_cyc_q.delete(); ov_cyc_q.delete();
        busy_cycles = 0;
    endtask

    // ---------------- reference model ----------------
    logic [VW-1:0] exp_nb[$], exp_wr[$];

    function automatic logic [VW-1:0] init_vec(input bit term);
        logic [VW-1:0] v;
        logic [BITS-1:0] neg;
        neg = BITS'(0) - BITS'(1 << (BITS - 2));
        for (int s = 0; s < STATES; s++) v[s*BITS +: BITS] = (term && s > 0) ? neg : '0;
        return v;
    endfunction

    function automatic logic [VW-1:0] norm_vec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        for (int s = 0; s < STATES; s++) r[s*BITS +: BITS] = v[s*BITS +: BITS] - v[BITS-1:0];
        return r;
    endfunction

    task automatic build_expected(input int n, input bit term, input int mode);
        logic [VW-1:0] beta;
        exp_nb.delete(); exp_wr.delete();
        beta = init_vec(term);
        for (int k = n - 1; k >= 0; k--) begin
            exp_nb.push_back(beta);
            beta = elem_fn(mode, beta, bm_mem[k]);
`ifdef BETA_RECURSION_CTRL_NORM_EN
            beta = norm_vec(beta);
`endif
            exp_wr.push_back(beta);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic bit in_wait(input int c, input int n);
        int ph;
        if (c < 2 || c > 1 + n * PERIOD) return 1'b0;
        ph = (c - 2) % PERIOD;
        return (ph >= 2 && ph <= ELEM_LATENCY + 1);
    endfunction

    task automatic launch(input int n, input bit term);
        @(negedge clk);
        clear_mon();
        base       = cyc;
        start      = 1'b1;
        block_len  = (ADDR_BITS+1)'(n);
        terminated = term;
    endtask

    task automatic run_cycles(input int from, input int upto, input bit spurious,
                              input bit pulse_again, input int n, input int abort_at);
        for (int c = from; c <= upto; c++) begin
            @(negedge clk);
            start      = pulse_again && (c == 4 || c == PERIOD + 3 || c == 2 + n * PERIOD);
            block_len  = (ADDR_BITS+1)'($urandom_range(0, 1 << ADDR_BITS));
            terminated = 1'($urandom_range(0, 1));
            spur       = spurious && !in_wait(c, n) && ($urandom_range(0, 1) == 1);
            abort      = (c == abort_at);
        end
        start = 1'b0;
        spur  = 1'b0;
        abort = 1'b0;
    endtask

    task automatic fill_bm(input int n);
        for (int k = 0; k < n; k++) bm_mem[k] = {$urandom, $urandom};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_count++;
        if ({busy, done, bm_rd_en, bm_rd_addr, elem_in_valid, elem_branch_metric, elem_next_beta,
             beta_wr_en, beta_wr_addr, beta_wr_data} !== '0) begin
            err_count++;
            $display("FAIL reset_outputs got busy=%b done=%b rd=%b iv=%b wr=%b nb=%h want all zero",
                     busy, done, bm_rd_en, elem_in_valid, beta_wr_en, elem_next_beta);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_count++;
        if (busy !== 1'b0) begin
            err_count++;
            $display("FAIL reset_idle got busy=%b want 0", busy);
        end
    endtask

    // Full block run compared against the reference model.
    task automatic test_block(input string name, input int n, input bit term, input int mode,
                              input bit spurious, input bit pulse_again);
        int exp_done, m;
        exp_done  = 2 + n * PERIOD;
        elem_mode = mode;
        fill_bm(n);
        build_expected(n, term, mode);
        launch(n, term);
        run_cycles(1, exp_done + 3, spurious, pulse_again, n, -1);

        check_count++;
        if (rd_addr_q.size() != n || is_cyc_q.size() != n || wr_addr_q.size() != n) begin
            err_count++;
            $display("FAIL %s counts got rd=%0d issue=%0d wr=%0d want %0d each",
                     name, rd_addr_q.size(), is_cyc_q.size(), wr_addr_q.size(), n);
        end
        m = (rd_addr_q.size() < n) ? rd_addr_q.size() : n;
        for (int i = 0; i < m; i++) begin
            check_count++;
            if (rd_addr_q[i] != n - 1 - i || rd_cyc_q[i] != 2 + i * PERIOD) begin
                err_count++;
                $display("FAIL %s read[%0d] got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                         name, i, rd_addr_q[i], rd_cyc_q[i], n - 1 - i, 2 + i * PERIOD);
            end
        end
        m = (is_cyc_q.size() < n) ? is_cyc_q.size() : n;
        for (int i = 0; i < m; i++) begin
            check_count++;
            if (is_nb_q[i] !== exp_nb[i] || is_bm_q[i] !== bm_mem[n-1-i] || is_cyc_q[i] != 3 + i * PERIOD) begin
                err_count++;
                $display("FAIL %s issue[%0d] got nb=%h bm=%h cyc=%0d want nb=%h bm=%h cyc=%0d",
                         name, i, is_nb_q[i], is_bm_q[i], is_cyc_q[i], exp_nb[i], bm_mem[n-1-i], 3 + i * PERIOD);
            end
        end
        m = (wr_addr_q.size() < n) ? wr_addr_q.size() : n;
        for (int i = 0; i < m; i++) begin
            check_count++;
            if (wr_addr_q[i] != n - 1 - i || wr_data_q[i] !== exp_wr[i] || wr_cyc_q[i] != 1 + (i + 1) * PERIOD) begin
                err_count++;
                $display("FAIL %s write[%0d] got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         name, i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], n - 1 - i, exp_wr[i], 1 + (i + 1) * PERIOD);
            end
        end
        check_count++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != exp_done) begin
            err_count++;
            $display("FAIL %s done got pulses=%0d first=%0d want 1 pulse at %0d",
                     name, done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, exp_done);
        end
        check_count++;
        if (busy_cycles != exp_done || busy !== 1'b0) begin
            err_count++;
            $display("FAIL %s busy got cycles=%0d now=%b want cycles=%0d now=0", name, busy_cycles, busy, exp_done);
        end
    endtask

    task automatic test_basic();
        logic [VW-1:0] first_nb;
        test_block("basic_n4_term", 4, 1'b1, 0, 1'b0, 1'b0);
        first_nb = {BITS'(-16384), BITS'(-16384), BITS'(-16384), BITS'(0)};
        check_count++;
        if (is_nb_q.size() == 0 || is_nb_q[0] !== first_nb) begin
            err_count++;
            $display("FAIL basic_first_next_beta got %h want %h",
                     (is_nb_q.size() > 0) ? is_nb_q[0] : '0, first_nb);
        end
        check_count++;
        if (done_cyc_q.size() == 0 || done_cyc_q[0] != 22) begin
            err_count++;
            $display("FAIL basic_done_cycle got %0d want 22", (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
        end
    endtask

    task automatic test_zero_len();
        launch(0, 1'($urandom_range(0, 1)));
        run_cycles(1, 6, 1'b0, 1'b0, 0, -1);
        check_count++;
        if (rd_addr_q.size() != 0 || is_cyc_q.size() != 0 || wr_addr_q.size() != 0) begin
            err_count++;
            $display("FAIL zero_len_strobes got rd=%0d issue=%0d wr=%0d want 0",
                     rd_addr_q.size(), is_cyc_q.size(), wr_addr_q.size());
        end
        check_count++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != 1 || busy_cycles != 1) begin
            err_count++;
            $display("FAIL zero_len_done got pulses=%0d busy_cycles=%0d want 1 pulse at cycle 1, busy 1 cycle",
                     done_cyc_q.size(), busy_cycles);
        end
    endtask

    task automatic test_abort();
        int ab;
        ab        = 3 * PERIOD;          // cycle of the third element result
        elem_mode = 2;
        fill_bm(4);
        launch(4, 1'b1);
        run_cycles(1, ab + 1, 1'b0, 1'b0, 4, ab);
        check_count++;
        if (busy !== 1'b0 || beta_wr_en !== 1'b0 || done !== 1'b0) begin
            err_count++;
            $display("FAIL abort_next_cycle got busy=%b wr=%b done=%b want 0 0 0", busy, beta_wr_en, done);
        end
        run_cycles(ab + 2, ab + 12, 1'b0, 1'b0, 4, -1);
        check_count++;
        if (ov_cyc_q.size() < 3 || ov_cyc_q[2] != ab) begin
            err_count++;
            $display("FAIL abort_alignment got third out_valid at %0d want %0d",
                     (ov_cyc_q.size() > 2) ? ov_cyc_q[2] : -1, ab);
        end
        check_count++;
        if (wr_addr_q.size() != 2 || done_cyc_q.size() != 0 || is_cyc_q.size() != 3) begin
            err_count++;
            $display("FAIL abort_effects got writes=%0d done=%0d issues=%0d want 2 0 3",
                     wr_addr_q.size(), done_cyc_q.size(), is_cyc_q.size());
        end
        test_block("after_abort", 3, 1'b0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        elem_mode = 2;
        fill_bm(8);
        launch(8, 1'b1);
        run_cycles(1, 4 + PERIOD, 1'b0, 1'b0, 8, -1);   // first WAIT cycle of step 2
        check_count++;
        if (is_cyc_q.size() != 2 || busy !== 1'b1) begin
            err_count++;
            $display("FAIL reset_mid_setup got issues=%0d busy=%b want 2 1", is_cyc_q.size(), busy);
        end
        reset = 1'b1;
        @(negedge clk);
        check_count++;
        if ({busy, done, bm_rd_en, bm_rd_addr, elem_in_valid, elem_branch_metric, elem_next_beta,
             beta_wr_en, beta_wr_addr, beta_wr_data} !== '0) begin
            err_count++;
            $display("FAIL reset_mid_outputs got busy=%b nb=%h iv=%b wr=%b want all zero",
                     busy, elem_next_beta, elem_in_valid, beta_wr_en);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        test_block("after_reset", 8, 1'b1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_const_element();
        logic [VW-1:0] want;
`ifdef BETA_RECURSION_CTRL_NORM_EN
        want = {BITS'(-30), BITS'(-20), BITS'(-10), BITS'(0)};
`else
        want = {BITS'(70), BITS'(80), BITS'(90), BITS'(100)};
`endif
        test_block("const_element", 3, 1'($urandom_range(0, 1)), 1, 1'b0, 1'b0);
        check_count++;
        if (wr_data_q.size() == 0 || wr_data_q[0] !== want) begin
            err_count++;
            $display("FAIL const_element_data got %h want %h", (wr_data_q.size() > 0) ? wr_data_q[0] : '0, want);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            test_block("random_block", $urandom_range(1, 12), 1'($urandom_range(0, 1)), 2,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_block("start_while_busy", 5, 1'b0, 2, 1'b0, 1'b1);
        test_block("spurious_valid", 6, 1'b1, 2, 1'b1, 1'b0);
        test_abort();
        test_reset_mid();
        test_const_element();
        test_block("single_step", 1, 1'b1, 2, 1'b0, 1'b0);
        test_block("max_block", 1 << ADDR_BITS, 1'b0, 2, 1'b0, 1'b0);
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", check_count, err_count);
        $finish;
    end

endmodule

// File: doc/beta_recursion_ctrl.md
Name: beta_recursion_ctrl

Overview:
- Sequences the backward (beta) recursion of the max-product SISO decoder over one code block.
- Reads per-step branch metrics from the branch-metric RAM in descending trellis index.
- Drives one beta_element instance, feeding each step's result back as nextBeta for the following step.
- Writes each beta vector to the beta RAM for the later LLR stage; reports busy/done.

Parameters:
- BITS, 16, metric width (two's complement).
- STATES, 4, trellis states.
- OUTPUT_SYMBOLS, 4, branch metrics per trellis step.
- ADDR_BITS, 10, trellis index width (max block 2^ADDR_BITS steps).
- ELEM_LATENCY, 2, cycles from beta_element in_valid to out_valid (at least 1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- abort  in  1  synchronous cancel of the current block
- block_len  in  ADDR_BITS+1  trellis steps N (0..2^ADDR_BITS); sampled with start
- terminated  in  1  trellis terminated to state 0; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when block finishes
- bm_rd_en  out  1  branch-metric RAM read strobe
- bm_rd_addr  out  ADDR_BITS  step index k
- bm_rd_data  in  BITS*OUTPUT_SYMBOLS  valid exactly one cycle after bm_rd_en
- elem_in_valid  out  1  to beta_element in_valid
- elem_branch_metric  out  BITS*OUTPUT_SYMBOLS  to beta_element branch_metric
- elem_next_beta  out  BITS*STATES  to beta_element nextBeta
- elem_out_valid  in  1  from beta_element out_valid
- elem_beta  in  BITS*STATES  from beta_element BetaMetric
- beta_wr_en  out  1  beta RAM write strobe
- beta_wr_addr  out  ADDR_BITS  step index k
- beta_wr_data  out  BITS*STATES  beta vector for step k

Behaviour:
- Reset: state IDLE; all outputs 0; beta_reg 0; step counter 0.
- FSM states: IDLE, INIT, READ, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - On start with N>0: latch N and terminated, set k=N-1, go to INIT.
  - On start with N=0: go directly to DONE; no reads, writes or issues.
  - Start is ignored outside IDLE.
- INIT (1 cycle): load beta_reg.
  - terminated=1: state 0 = 0, others = NEG_INIT = -2^(BITS-2).
  - terminated=0: all states 0.
- READ (1 cycle): bm_rd_en=1, bm_rd_addr=k.
- ISSUE (1 cycle): elem_in_valid=1, elem_branch_metric=bm_rd_data, elem_next_beta=beta_reg.
- WAIT:
  - Hold elem_in_valid=0 and elem_next_beta stable.
  - On elem_out_valid: latch elem_beta (after optional normalisation) into beta_reg, go to WRITE.
  - elem_out_valid arrives ELEM_LATENCY cycles after ISSUE.
- WRITE (1 cycle): beta_wr_en=1, beta_wr_addr=k, beta_wr_data=beta_reg. If k==0 go to DONE; else k=k-1, go to READ.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- Timing:
  - Step period is ELEM_LATENCY+3 cycles.
  - With start sampled at edge 0: first READ in cycle 2; last WRITE in cycle 1+N*(ELEM_LATENCY+3); done in cycle 2+N*(ELEM_LATENCY+3).
- Exactly one element request is in flight at a time; the recursion dependency forbids overlap.
- elem_out_valid outside WAIT is ignored.
- abort in any non-IDLE state: go to IDLE next cycle. No done pulse, no further strobes. beta_reg keeps its value; RAM contents already written stay as written.
- abort in the same cycle as elem_out_valid: abort wins, no write.
- Reset asserted mid-block: immediate return to reset values.
- Arithmetic wraps modulo 2^BITS; no saturation.

Optional Feature:
- Macro: BETA_RECURSION_CTRL_NORM_EN.
- Defined: on latch, subtract elem_beta state 0 from every state, so beta_reg state 0 is always 0. Keeps metrics bounded for long blocks.
- Undefined: elem_beta latched unmodified; no subtractors instantiated.
- Timing is identical in both builds.

Decomposition:
- Shared package turbo_ctrl_pkg: state enum beta_ctrl_state_t, NEG_INIT function of BITS, packed metric-vector typedefs reused by alpha-side controller.
- One natural sub-module: beta_norm (combinational per-state subtract-reference), instantiated only under the macro.

Test Plan:
- Reset during WAIT of step 2 with N=8: all outputs 0 next cycle. A new start then completes with 8 writes.
- N=0, start: done one cycle after IDLE exit; zero bm_rd_en, elem_in_valid and beta_wr_en.
- N=4, terminated=1, ELEM_LATENCY=2, model element returns input+1:
  - Reads at addr 3,2,1,0.
  - First elem_next_beta = {0,-16384,-16384,-16384}.
  - Done in cycle 22.
- Start pulsed again while busy: ignored, sequence unchanged.
- abort in same cycle as third elem_out_valid (N=4): no third write, no done, busy low next cycle.
- NORM_EN build, element returns {100,90,80,70}: beta_wr_data = {0,-10,-20,-30}. Without the macro: beta_wr_data = {100,90,80,70}.
